// File: rtl/mem_stage.sv
// mem_stage: registers the execute result, runs one data-memory access
// per load/store over a req/ack port, and hands one result to write-back.
module mem_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [WORD_W-1:0] i_exResult,
  input  logic [1:0]        i_memOp,
  input  logic [1:0]        i_memSize,
  input  logic              i_signExt,
  input  logic [WORD_W-1:0] i_storeData,
  input  logic [REG_W-1:0]  i_regDst,
  input  logic              i_regWrite,
  output logic              o_stall,
  output logic              o_memReq,
  output logic              o_memWe,
  output logic [WORD_W-1:0] o_memAddr,
  output logic [3:0]        o_memByteEn,
  output logic [WORD_W-1:0] o_memWdata,
  input  logic              i_memAck,
  input  logic [WORD_W-1:0] i_memRdata,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_result,
  output logic [REG_W-1:0]  o_regDst,
  output logic              o_regWrite,
  output logic              o_misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;

  // Operands of the access in flight.
  typedef struct packed {
    logic [1:0]       size;
    logic [1:0]       off;
    logic             sext;
    logic             load;
    logic [REG_W-1:0] dst;
    logic             wr;
  } acc_t;

  // A non-memory result that arrived on the ack edge and waits one
  // cycle behind the load/store result.
  typedef struct packed {
    logic [WORD_W-1:0] result;
    logic [REG_W-1:0]  dst;
    logic              wr;
    logic              mis;
  } skid_t;

  state_t state;
  acc_t   acc;
  skid_t  skid;

  logic              in_load;
  logic              in_mem;
  logic [1:0]        in_size;
  logic              in_mis;
  logic              in_go;
  logic [3:0]        in_be;
  logic [WORD_W-1:0] in_wdata;
  logic              nm_wr;
  logic [WORD_W-1:0] rd_shift;
  logic [WORD_W-1:0] ld_data;
  logic [WORD_W-1:0] st_addr;

  // Decode the incoming instruction: op, size, alignment, lanes.
  always_comb begin
    in_load  = (i_memOp == OP_LOAD);
    in_mem   = in_load || (i_memOp == OP_STORE);
    in_size  = (i_memSize == 2'd3) ? SZ_WORD : i_memSize;
    in_mis   = 1'b0;
    in_be    = 4'b1111;
    in_wdata = i_storeData;
    unique case (1'b1)
      (in_size == SZ_BYTE): begin
        in_be    = 4'b0001 << i_exResult[1:0];
        in_wdata = {(WORD_W/8){i_storeData[7:0]}};
      end
      (in_size == SZ_HALF): begin
        in_mis   = i_exResult[0];
        in_be    = 4'b0011 << i_exResult[1:0];
        in_wdata = {(WORD_W/16){i_storeData[15:0]}};
      end
      default: begin
        in_mis = |i_exResult[1:0];
      end
    endcase
    in_go = in_mem && !in_mis;
    nm_wr = !in_mem && i_regWrite;
  end

  // Pick the addressed lane of the read word and extend it.
  always_comb begin
    rd_shift = i_memRdata >> {acc.off, 3'b000};
    ld_data  = rd_shift;
    unique case (1'b1)
      (acc.size == SZ_BYTE):
        ld_data = {{(WORD_W-8){acc.sext & rd_shift[7]}},
                   rd_shift[7:0]};
      (acc.size == SZ_HALF):
        ld_data = {{(WORD_W-16){acc.sext & rd_shift[15]}},
                   rd_shift[15:0]};
      default:
        ld_data = rd_shift;
    endcase
    st_addr = {o_memAddr[WORD_W-1:2], acc.off};
  end

  // Hold upstream while waiting for ack, and for the one drain cycle.
  always_comb begin
    o_stall = ((state == REQ) && !i_memAck) || (state == DRAIN);
  end

  // Main FSM with registered memory-port and write-back outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      skid        <= '0;
      o_memReq    <= 1'b0;
      o_memWe     <= 1'b0;
      o_memAddr   <= '0;
      o_memByteEn <= 4'b0000;
      o_memWdata  <= '0;
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_regDst    <= '0;
      o_regWrite  <= 1'b0;
      o_misalign  <= 1'b0;
    end else begin
      o_valid    <= 1'b0;
      o_misalign <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_valid && in_go) begin
            state       <= REQ;
            acc.size    <= in_size;
            acc.off     <= i_exResult[1:0];
            acc.sext    <= i_signExt;
            acc.load    <= in_load;
            acc.dst     <= i_regDst;
            acc.wr      <= i_regWrite;
            o_memReq    <= 1'b1;
            o_memWe     <= !in_load;
            o_memAddr   <= {i_exResult[WORD_W-1:2], 2'b00};
            o_memByteEn <= in_be;
            o_memWdata  <= in_wdata;
          end else if (i_valid) begin
            o_valid    <= 1'b1;
            o_result   <= i_exResult;
            o_regDst   <= i_regDst;
            o_regWrite <= nm_wr;
            o_misalign <= in_mem;
          end
        end
        REQ: begin
          if (i_memAck) begin
            state       <= IDLE;
            o_memReq    <= 1'b0;
            o_memWe     <= 1'b0;
            o_memByteEn <= 4'b0000;
            o_valid     <= 1'b1;
            o_result    <= acc.load ? ld_data : st_addr;
            o_regDst    <= acc.dst;
            o_regWrite  <= acc.load && acc.wr;
            if (i_valid && in_go) begin
              state       <= REQ;
              acc.size    <= in_size;
              acc.off     <= i_exResult[1:0];
              acc.sext    <= i_signExt;
              acc.load    <= in_load;
              acc.dst     <= i_regDst;
              acc.wr      <= i_regWrite;
              o_memReq    <= 1'b1;
              o_memWe     <= !in_load;
              o_memAddr   <= {i_exResult[WORD_W-1:2], 2'b00};
              o_memByteEn <= in_be;
              o_memWdata  <= in_wdata;
            end else if (i_valid) begin
              state       <= DRAIN;
              skid.result <= i_exResult;
              skid.dst    <= i_regDst;
              skid.wr     <= nm_wr;
              skid.mis    <= in_mem;
            end
          end
        end
        DRAIN: begin
          state      <= IDLE;
          o_valid    <= 1'b1;
          o_result   <= skid.result;
          o_regDst   <= skid.dst;
          o_regWrite <= skid.wr;
          o_misalign <= skid.mis;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage pass-through, loads,
// stores, misalignment, back-to-back issue and mid-access reset.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] ex_result;
  logic [1:0]  mem_op;
  logic [1:0]  mem_size;
  logic        sign_ext;
  logic [31:0] store_data;
  logic [4:0]  reg_dst;
  logic        reg_write;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_dst;
  logic        out_wr;
  logic        out_mis;

  int checks;
  int errors;

  mem_stage #(.WORD_W(32), .REG_W(5)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_exResult  (ex_result),
    .i_memOp     (mem_op),
    .i_memSize   (mem_size),
    .i_signExt   (sign_ext),
    .i_storeData (store_data),
    .i_regDst    (reg_dst),
    .i_regWrite  (reg_write),
    .o_stall     (stall),
    .o_memReq    (mem_req),
    .o_memWe     (mem_we),
    .o_memAddr   (mem_addr),
    .o_memByteEn (mem_be),
    .o_memWdata  (mem_wdata),
    .i_memAck    (mem_ack),
    .i_memRdata  (mem_rdata),
    .o_valid     (out_valid),
    .o_result    (out_result),
    .o_regDst    (out_dst),
    .o_regWrite  (out_wr),
    .o_misalign  (out_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: no finish after 200000 time units");
    $fatal(1);
  end

  task automatic idle_inputs();
    valid      = 1'b0;
    ex_result  = 32'h0;
    mem_op     = 2'd0;
    mem_size   = 2'd0;
    sign_ext   = 1'b0;
    store_data = 32'h0;
    reg_dst    = 5'd0;
    reg_write  = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, mem_req, mem_we, out_valid, out_wr, out_mis} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {stall, mem_req, mem_we, out_valid, out_wr, out_mis});
    end
    checks++;
    if ({mem_addr, mem_be, mem_wdata, out_result, out_dst} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %h be %b wd %h res %h dst %0d",
               mem_addr, mem_be, mem_wdata, out_result, out_dst);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    valid     = 1'b1;
    mem_op    = 2'd0;
    ex_result = 32'hDEADBEEF;
    reg_dst   = 5'd5;
    reg_write = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL pass_stall: got %b want 0", stall);
    end
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if ({out_valid, out_result, out_dst, out_wr, out_mis, mem_req}
        !== {1'b1, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pass_out: v %b res %h dst %0d wr %b mis %b req %b want 1 deadbeef 5 1 0 0",
               out_valid, out_result, out_dst, out_wr, out_mis, mem_req);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pass_pulse: o_valid %b want 0", out_valid);
    end
    idle_inputs();
  endtask

  task automatic test_byte_load(input logic sx, input logic [31:0] exp);
    valid     = 1'b1;
    mem_op    = 2'd1;
    mem_size  = 2'd0;
    sign_ext  = sx;
    ex_result = 32'h103;
    reg_dst   = 5'd4;
    reg_write = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be, stall, out_valid}
          !== {1'b1, 1'b0, 32'h100, 4'b1000, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL bload_req%0d: req %b we %b addr %h be %b stall %b v %b",
                 c, mem_req, mem_we, mem_addr, mem_be, stall, out_valid);
      end
    end
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h80FFFFFF;
    valid     = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL bload_ackstall: got %b want 0", stall);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({out_valid, out_result, out_dst, out_wr, mem_req}
        !== {1'b1, exp, 5'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL bload_res sx=%b: v %b res %h dst %0d wr %b req %b want res %h",
               sx, out_valid, out_result, out_dst, out_wr, mem_req, exp);
    end
    idle_inputs();
  endtask

  task automatic test_half_store();
    valid      = 1'b1;
    mem_op     = 2'd2;
    mem_size   = 2'd1;
    ex_result  = 32'h202;
    store_data = 32'h1234ABCD;
    reg_dst    = 5'd6;
    reg_write  = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata}
        !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD}) begin
      errors++;
      $display("FAIL hstore_req: req %b we %b addr %h be %b wd %h",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    mem_ack = 1'b1;
    valid   = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({out_valid, out_wr, mem_req, out_mis} !== 4'b1000) begin
      errors++;
      $display("FAIL hstore_done: v %b wr %b req %b mis %b want 1 0 0 0",
               out_valid, out_wr, mem_req, out_mis);
    end
    idle_inputs();
  endtask

  task automatic test_misaligned();
    valid     = 1'b1;
    mem_op    = 2'd1;
    mem_size  = 2'd2;
    ex_result = 32'h301;
    reg_dst   = 5'd7;
    reg_write = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if ({mem_req, out_valid, out_mis, out_wr, out_result, stall}
        !== {1'b0, 1'b1, 1'b1, 1'b0, 32'h301, 1'b0}) begin
      errors++;
      $display("FAIL misalign: req %b v %b mis %b wr %b res %h stall %b",
               mem_req, out_valid, out_mis, out_wr, out_result, stall);
    end
    @(negedge clk);
    checks++;
    if ({mem_req, out_valid, out_mis} !== 3'b000) begin
      errors++;
      $display("FAIL misalign_after: req %b v %b mis %b want 000",
               mem_req, out_valid, out_mis);
    end
    idle_inputs();
  endtask

  task automatic test_reserved();
    valid     = 1'b1;
    mem_op    = 2'd3;
    ex_result = 32'h0BADF00D;
    reg_dst   = 5'd8;
    reg_write = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, out_valid, out_result, out_wr}
        !== {1'b0, 1'b1, 32'h0BADF00D, 1'b1}) begin
      errors++;
      $display("FAIL rsv_op: req %b v %b res %h wr %b",
               mem_req, out_valid, out_result, out_wr);
    end
    mem_op    = 2'd1;
    mem_size  = 2'd3;
    ex_result = 32'h24;
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h24, 4'b1111}) begin
      errors++;
      $display("FAIL rsv_size: req %b addr %h be %b want 1 24 1111",
               mem_req, mem_addr, mem_be);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h89ABCDEF;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({out_valid, out_result} !== {1'b1, 32'h89ABCDEF}) begin
      errors++;
      $display("FAIL rsv_word: v %b res %h want 1 89abcdef",
               out_valid, out_result);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    valid     = 1'b1;
    mem_op    = 2'd1;
    mem_size  = 2'd1;
    sign_ext  = 1'b1;
    ex_result = 32'h12;
    reg_dst   = 5'd3;
    reg_write = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_be} !== {1'b1, 4'b1100}) begin
      errors++;
      $display("FAIL b2b_req: req %b be %b want 1 1100", mem_req, mem_be);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h7FFE0000;
    mem_op    = 2'd0;
    ex_result = 32'h12345678;
    reg_dst   = 5'd9;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ackstall: got %b want 0", stall);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    valid   = 1'b0;
    checks++;
    if ({out_valid, out_result, out_dst, out_wr, mem_req}
        !== {1'b1, 32'h00007FFE, 5'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first: v %b res %h dst %0d wr %b req %b want 1 00007ffe 3 1 0",
               out_valid, out_result, out_dst, out_wr, mem_req);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_result, out_dst, out_wr}
        !== {1'b1, 32'h12345678, 5'd9, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second: v %b res %h dst %0d wr %b want 1 12345678 9 1",
               out_valid, out_result, out_dst, out_wr);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, stall, mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_nodup: v %b stall %b req %b want 000",
               out_valid, stall, mem_req);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    valid     = 1'b1;
    mem_op    = 2'd1;
    mem_size  = 2'd2;
    ex_result = 32'h40;
    reg_dst   = 5'd2;
    reg_write = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rmid_req: got %b want 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, mem_req, mem_we, out_valid, mem_be, mem_addr}
        !== {4'b0, 4'b0, 32'h0}) begin
      errors++;
      $display("FAIL rmid_async: stall %b req %b we %b v %b be %b addr %h",
               stall, mem_req, mem_we, out_valid, mem_be, mem_addr);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({out_valid, mem_req, stall} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_lateack: v %b req %b stall %b want 000",
               out_valid, mem_req, stall);
    end
    valid     = 1'b1;
    mem_op    = 2'd0;
    ex_result = 32'hAAAA5555;
    reg_dst   = 5'd11;
    reg_write = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if ({out_valid, out_result, out_dst, out_wr}
        !== {1'b1, 32'hAAAA5555, 5'd11, 1'b1}) begin
      errors++;
      $display("FAIL rmid_fresh: v %b res %h dst %0d wr %b",
               out_valid, out_result, out_dst, out_wr);
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_passthrough();
    test_byte_load(1'b1, 32'hFFFFFF80);
    test_byte_load(1'b0, 32'h00000080);
    test_half_store();
    test_misaligned();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the execute-stage result bus.
- Registers ex_result and sideband, then either passes it to write-back unchanged (non-memory ops) or uses it as the data-memory address for a load or store.
- Drives a request/acknowledge data-memory port, stalls upstream while an access is outstanding, and presents one aligned, extended result per instruction to write-back.

Parameters:
- WORD_W, 32, datapath and address width
- REG_W, 5, register index width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous reset, active low
- i_valid  in  1  instruction present from execute stage
- i_exResult  in  WORD_W  ex_result bus: ALU value, or effective address for memory ops
- i_memOp  in  2  0 none, 1 load, 2 store, 3 reserved (treated as none)
- i_memSize  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
- i_signExt  in  1  loads: 1 sign-extend, 0 zero-extend
- i_storeData  in  WORD_W  store source register value
- i_regDst  in  REG_W  destination register
- i_regWrite  in  1  destination write enable
- o_stall  out  1  upstream must hold its outputs this cycle
- o_memReq  out  1  data-memory request
- o_memWe  out  1  1 store, 0 load
- o_memAddr  out  WORD_W  word-aligned address (low 2 bits zero)
- o_memByteEn  out  4  byte-lane enables, lane n = bits 8n+7:8n
- o_memWdata  out  WORD_W  store data placed on lanes
- i_memAck  in  1  access complete; i_memRdata valid this cycle for loads
- i_memRdata  in  WORD_W  read word
- o_valid  out  1  result valid to write-back, one-cycle pulse per instruction
- o_result  out  WORD_W  write-back value
- o_regDst  out  REG_W  write-back register
- o_regWrite  out  1  write-back enable, qualified by o_valid
- o_misalign  out  1  pulses with o_valid when access was misaligned

Behaviour:
- Reset (async, i_rst_n low):
  - State IDLE.
  - All outputs zero, including o_stall, o_memReq, o_valid and o_misalign.
  - Reset mid-access abandons the access. The memory side must tolerate a dropped request.
- State IDLE, o_stall = 0, inputs sampled every rising edge:
  - i_valid, op none: next cycle o_valid=1, o_result=i_exResult, o_regDst/o_regWrite copied. Latency 1.
  - i_valid, load or store, aligned: latch operands; go to REQ.
  - i_valid, load or store, misaligned (half with addr[0]=1, or word with addr[1:0]≠0): no memory access; next cycle o_valid=1, o_misalign=1, o_regWrite=0, o_result=address.
  - i_valid=0: o_valid=0.
- State REQ:
  - o_memReq=1 and o_stall=1.
  - o_memAddr={addr[WORD_W-1:2],2'b00} and o_memWe held stable until ack.
  - Byte enables: byte 1<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - o_memWdata: byte replicated ×4, half replicated ×2, word as-is.
  - No ack: remain in REQ. There is no timeout.
  - i_memAck=1: deassert o_memReq next cycle and go to IDLE.
    - Next cycle o_valid=1.
    - Store: o_regWrite=0.
    - Load: o_result = lane-selected read data shifted to bit 0, then sign- or zero-extended to WORD_W.
  - o_stall drops in the ack cycle (combinational on i_memAck), so upstream advances and a new instruction is sampled on the same edge. Back-to-back memory ops therefore lose no cycle beyond the memory latency.
- Minimum memory op latency: 2 cycles (issue edge to o_valid) with ack in the first REQ cycle.
- i_memAck while in IDLE is ignored.
- i_valid while o_stall=1: the inputs are upstream's held values and are not re-sampled.
- Outputs are registered except o_stall.
- Reserved encodings follow the mappings stated under Ports.

Test Plan:
- Pass-through: i_valid, op none, i_exResult=32'hDEADBEEF, regDst=5, regWrite=1 → one cycle later o_valid=1, o_result=DEADBEEF, o_regDst=5, o_regWrite=1; o_memReq stays 0.
- Signed byte load: addr=32'h103, memRdata=32'h80FFFFFF, ack after 3 REQ cycles.
  - During REQ: o_memAddr=32'h100, byteEn=4'b1000, o_stall=1 for 3 cycles.
  - Result: o_result=32'hFFFFFF80.
  - Repeat with signExt=0: o_result=32'h00000080.
- Half store: addr=32'h202, storeData=32'h1234ABCD, immediate ack → o_memWe=1, byteEn=4'b1100, o_memWdata=32'hABCDABCD; o_valid with o_regWrite=0.
- Misaligned word load at 32'h301 → no o_memReq; next cycle o_valid=1, o_misalign=1, o_regWrite=0, o_result=32'h301.
- Back-to-back: load (immediate ack) followed by an op-none instruction presented during the ack cycle → o_valid on two consecutive cycles, correct values, no lost or duplicated instruction.
- Reset mid-REQ: drop i_rst_n while o_memReq=1 → all outputs 0 immediately without a clock; after release, a fresh op-none instruction completes normally; a late i_memAck arriving in IDLE is ignored.
